// File: rtl/act_pkg.sv
// act_pkg: shared mode encodings, default widths and sigmoid LUT entry generator
package act_pkg;
  typedef enum logic [1:0] {
    ACT_SIGMOID = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_STEP    = 2'd2,
    ACT_RSVD    = 2'd3
  } act_mode_e;
  localparam int IN_W_D    = 22;
  localparam int FRAC_W_D  = 14;
  localparam int LUT_INT_D = 3;
  localparam int ADDR_W_D  = 9;
  localparam int OUT_W_D   = 8;
  localparam int CNT_W_D   = 16;
  localparam int LUT_Q     = 60;
  // round(2^out_w / (1 + e^-t)) with t = a * 2^(lut_int-addr_w), evaluated in Q60 integer math
  function automatic int lut_entry(input int a, input int addr_w, input int lut_int, input int out_w);
    logic [127:0] one, b, t, r, p, q;
    int mx;
    one = 128'd1 << LUT_Q;
    b = one;
    t = one;
    for (int k = 1; k < 32; k++) begin
      t = (t >> (addr_w - lut_int)) / 128'(k);
      b = k[0] ? b - t : b + t;
    end
    r = one;
    p = b;
    for (int i = 0; i < 31; i++) begin
      if (a[i]) r = (r * p) >> LUT_Q;
      p = (p * p) >> LUT_Q;
    end
    q = ((one << (out_w + 1)) + one + r) / ((one + r) << 1);
    mx = (1 << out_w) - 1;
    lut_entry = (q > 128'(mx)) ? mx : int'(q[31:0]);
  endfunction
endpackage

// File: rtl/act_sigmoid_rom.sv
// act_sigmoid_rom: synchronous-read sigmoid ROM, contents generated at elaboration
module act_sigmoid_rom
  import act_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int LUT_INT = LUT_INT_D
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [OUT_W-1:0]  o_data
);
  logic [OUT_W-1:0] w_rom [1<<ADDR_W];
  logic [OUT_W-1:0] r_data;
  for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_rom
    localparam logic [OUT_W-1:0] V = OUT_W'(lut_entry(i, ADDR_W, LUT_INT, OUT_W));
    assign w_rom[i] = V;
  end
  always_ff @(posedge clk)
    if (i_en) r_data <= w_rom[i_addr];
  assign o_data = r_data;
endmodule

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: 3-stage activation unit (sigmoid LUT / clipped ReLU / step) with backpressure and ovf counter
module act_unit_pipe
  import act_pkg::*;
#(
  parameter int IN_W    = IN_W_D,
  parameter int FRAC_W  = FRAC_W_D,
  parameter int LUT_INT = LUT_INT_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int CNT_W   = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] ovf_count
);
  localparam logic [OUT_W-1:0] M       = '1;
  localparam logic [IN_W:0]    OVF_LIM = (IN_W+1)'(1) << (FRAC_W + LUT_INT);
  localparam logic [IN_W:0]    ONE     = (IN_W+1)'(1) << FRAC_W;
  logic              w_en;
  logic              r_s0_v, r_s1_v, r_out_valid, r_out_ovf;
  logic [IN_W-1:0]   r_s0_x;
  act_mode_e         r_s0_m, r_s1_m;
  logic              w_neg, w_ovf, w_ge1;
  logic [IN_W:0]     w_mag;
  logic [ADDR_W-1:0] w_addr;
  logic              r_s1_neg, r_s1_ovf, r_s1_ge1;
  logic [OUT_W-1:0]  r_s1_frac, w_lut, w_sig, w_d, r_out_data;
  logic              w_o;
  logic [CNT_W-1:0]  r_cnt;
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  always_ff @(posedge clk)
    if (rst) r_s0_v <= 1'b0;
    else if (w_en) begin
      r_s0_v <= in_valid;
      r_s0_x <= in_data;
      r_s0_m <= act_mode_e'(in_mode);
    end
  // one extra magnitude bit keeps the most-negative input exact
  assign w_neg  = r_s0_x[IN_W-1];
  assign w_mag  = w_neg ? -{1'b1, r_s0_x} : {1'b0, r_s0_x};
  assign w_ovf  = w_mag >= OVF_LIM;
  assign w_ge1  = w_mag >= ONE;
  assign w_addr = w_mag[FRAC_W+LUT_INT-1 -: ADDR_W];
  act_sigmoid_rom #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .LUT_INT(LUT_INT)) u_rom (
    .clk   (clk),
    .i_en  (w_en),
    .i_addr(w_addr),
    .o_data(w_lut)
  );
  always_ff @(posedge clk)
    if (rst) r_s1_v <= 1'b0;
    else if (w_en) begin
      r_s1_v    <= r_s0_v;
      r_s1_m    <= r_s0_m;
      r_s1_neg  <= w_neg;
      r_s1_ovf  <= w_ovf;
      r_s1_ge1  <= w_ge1;
      r_s1_frac <= r_s0_x[FRAC_W-1 -: OUT_W];
    end
  always_comb begin
    w_sig = r_s1_ovf ? (r_s1_neg ? '0 : M) : (r_s1_neg ? M - w_lut : w_lut);
    w_d   = (r_s1_m == ACT_SIGMOID) ? w_sig :
            (r_s1_m == ACT_RELU)    ? (r_s1_neg ? '0 : (r_s1_ge1 ? M : r_s1_frac)) :
            (r_s1_m == ACT_STEP)    ? (r_s1_neg ? '0 : M) : '0;
    w_o   = (r_s1_m == ACT_SIGMOID) ? r_s1_ovf :
            (r_s1_m == ACT_RELU)    ? (!r_s1_neg && r_s1_ge1) : 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_v;
      r_out_data  <= w_d;
      r_out_ovf   <= w_o;
    end
  always_ff @(posedge clk)
    if (rst || cnt_clear) r_cnt <= '0;
    else if (r_out_valid && out_ready && r_out_ovf && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign ovf_count = r_cnt;
endmodule

// File: tb/tb_act_unit_pipe.sv
// tb_act_unit_pipe: randomized scoreboard bench with a real-arithmetic reference model
module tb_act_unit_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cnt_clear = 1'b0;
  logic [21:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [7:0]  out_data;
  logic [15:0] ovf_count;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [7:0]  out_data2;
  logic [1:0]  ovf2;
  always #5 clk = ~clk;
  act_unit_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .cnt_clear(cnt_clear), .ovf_count(ovf_count)
  );
  act_unit_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_ovf(out_ovf2), .cnt_clear(cnt_clear), .ovf_count(ovf2)
  );
  typedef struct {logic [7:0] d; logic o; int c; bit l;} exp_t;
  exp_t q[$];
  exp_t e;
  int cmp = 0, bad = 0, cyc = 0, bp_mode = 0, bp_cnt = 0, m16 = 0, m2 = 0;
  bit mon_on = 0, lat_chk = 0, inc;
  logic [7:0] md;
  logic mo;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    cmp++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", n, act, req);
    end
  endtask
  // reference: sigmoid/relu/step evaluated on the real value of x
  function automatic void model(input logic [21:0] x, input logic [1:0] m, output logic [7:0] d, output logic o);
    real v, s;
    int a;
    v = $itor($signed(x)) / 16384.0;
    d = 8'd0;
    o = 1'b0;
    if (m == 2'd0) begin
      if (v >= 8.0) begin d = 8'd255; o = 1'b1; end
      else if (v <= -8.0) o = 1'b1;
      else begin
        a = $rtoi((v < 0.0 ? -v : v) * 64.0);
        s = 256.0 / (1.0 + $exp(-a / 64.0));
        a = $rtoi(s + 0.5);
        if (a > 255) a = 255;
        d = (v < 0.0) ? 8'(255 - a) : 8'(a);
      end
    end else if (m == 2'd1) begin
      if (v >= 1.0) begin d = 8'd255; o = 1'b1; end
      else if (v >= 0.0) d = 8'($rtoi(v * 256.0));
    end else if (m == 2'd2) d = (v >= 0.0) ? 8'd255 : 8'd0;
  endfunction
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? (bp_cnt % 4 == 0 || bp_cnt % 4 == 3) : 1'($urandom_range(0, 1));
    bp_cnt++;
  end
  always @(negedge clk) if (mon_on) begin
    chk("ovf_count", 32'(ovf_count), m16);
    chk("ovf_count_w2", 32'(ovf2), m2);
    if (rst) begin
      q.delete();
      m16 = 0;
      m2 = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      inc = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL unexpected_out: got data %0d with nothing pending, required no output", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_ovf", 32'(out_ovf), 32'(e.o));
          if (e.l) chk("latency", cyc - e.c, 3);
          inc = e.o;
        end
      end
      if (cnt_clear) begin m16 = 0; m2 = 0; end
      else if (inc) begin
        if (m16 < 65535) m16++;
        if (m2 < 3) m2++;
      end
      if (in_valid && in_ready) begin
        model(in_data, in_mode, md, mo);
        q.push_back(exp_t'{d: md, o: mo, c: cyc, l: lat_chk});
      end
    end
  end
  task automatic send(input logic [21:0] x, input logic [1:0] m);
    bit ok = 0;
    in_valid = 1'b1;
    in_data = x;
    in_mode = m;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) @(posedge clk);
    end
    chk("accept", 32'(ok), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    chk("drain", q.size(), 0);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [21:0] x;
    @(posedge clk);
    #1 mon_on = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 lat_chk = 1;
    send(22'h000000, 2'd0);
    send(22'h004000, 2'd0);
    send(22'h3FC000, 2'd0);
    send(22'h020000, 2'd0);
    send(22'h200000, 2'd0);
    send(22'h002000, 2'd1);
    send(22'h3FE000, 2'd1);
    send(22'h004000, 2'd1);
    send(22'h3FFFFF, 2'd2);
    send(22'h000000, 2'd2);
    send(22'h123456, 2'd3);
    send(22'h3FFFFF, 2'd3);
    drain();
    lat_chk = 0;
    bp_mode = 1;
    for (int i = 0; i < 10; i++) send(22'($urandom), 2'($urandom_range(0, 2)));
    drain();
    bp_mode = 0;
    @(posedge clk);
    #1 cnt_clear = 1;
    @(posedge clk);
    #1 cnt_clear = 0;
    send(22'h020000, 2'd0);
    send(22'h200000, 2'd0);
    send(22'h006000, 2'd1);
    send(22'h1FFFFF, 2'd0);
    send(22'h004000, 2'd1);
    drain();
    @(negedge clk);
    chk("cnt_five", 32'(ovf_count), 5);
    chk("cnt_sat_w2", 32'(ovf2), 3);
    @(posedge clk);
    #1;
    send(22'h020000, 2'd0);
    repeat (2) @(posedge clk);
    #1 cnt_clear = 1;
    @(negedge clk);
    chk("sixth_ovf_present", 32'(out_valid && out_ovf), 1);
    @(posedge clk);
    #1 cnt_clear = 0;
    @(negedge clk);
    chk("cnt_clear_wins", 32'(ovf_count), 0);
    @(posedge clk);
    #1 bp_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: x = 22'($urandom);
        1: x = 22'($urandom_range(0, 65536) - 32768);
        2: x = 22'($urandom_range(0, 262144) - 131072);
        default: x = ($urandom_range(0, 1) != 0) ? 22'h200000 : 22'h01FFFF;
      endcase
      send(x, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    bp_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 22'h020000;
      in_mode = 2'd0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_ovf_count", 32'(ovf_count), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
